// File: rtl/square_wave_gen.sv
// Pulse (square-wave) tone channel: period timer, 8-step duty sequencer,
// length counter and sweep-overflow kill, with a registered sample output.
module square_wave_gen #(
  parameter int unsigned LENGTH_MAX = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freq_tick,
  input  logic        length_tick,
  input  logic [10:0] frequency,
  input  logic [1:0]  duty,
  input  logic        trigger,
  input  logic        length_enable,
  input  logic        length_load,
  input  logic [5:0]  length_data,
  input  logic        sweep_ok,
  output logic        wave_out,
  output logic        channel_on,
  output logic [2:0]  duty_step
);

  localparam int unsigned TIMER_W = 12;
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned STEP_W  = 3;

  logic [TIMER_W-1:0] r_timer;
  logic [STEP_W-1:0]  r_step;
  logic [LEN_W-1:0]   r_len;
  logic               r_on;
  logic               r_wave;

  logic [TIMER_W-1:0] w_timer;
  logic [STEP_W-1:0]  w_step;
  logic [LEN_W-1:0]   w_len;
  logic               w_on;
  logic               w_wave;
  logic [TIMER_W-1:0] w_reload;
  logic [LEN_W-1:0]   w_len_load;
  logic [7:0]         w_pattern;

  // Duty waveforms, bit n is the sample for step n
  always_comb begin
    w_pattern = 8'b0000_0001;
    case (duty)
      2'd0:    w_pattern = 8'b0000_0001;
      2'd1:    w_pattern = 8'b1000_0001;
      2'd2:    w_pattern = 8'b1000_0111;
      default: w_pattern = 8'b0111_1110;
    endcase
  end

  // Next-state: trigger dominates the timer/length paths, sweep overflow dominates everything
  always_comb begin
    w_reload   = TIMER_W'(2048) - TIMER_W'(frequency);
    w_len_load = LEN_W'(LENGTH_MAX) - LEN_W'(length_data);
    w_timer    = r_timer;
    w_step     = r_step;
    w_len      = r_len;
    w_on       = r_on;

    if (trigger) begin
      w_timer = w_reload;
      w_step  = '0;
      w_on    = 1'b1;
      if (length_load) begin
        w_len = (w_len_load == '0) ? LEN_W'(LENGTH_MAX) : w_len_load;
      end else if (r_len == '0) begin
        w_len = LEN_W'(LENGTH_MAX);
      end
    end else begin
      if (r_on && freq_tick) begin
        if (r_timer == TIMER_W'(1)) begin
          w_timer = w_reload;
          w_step  = r_step + STEP_W'(1);
        end else begin
          w_timer = r_timer - TIMER_W'(1);
        end
      end
      if (length_load) begin
        w_len = w_len_load;
      end else if (length_tick && length_enable && (r_len != '0)) begin
        w_len = r_len - LEN_W'(1);
        if (r_len == LEN_W'(1)) begin
          w_on = 1'b0;
        end
      end
    end

    if (!sweep_ok) begin
      w_on = 1'b0;
    end

    w_wave = w_pattern[w_step] & w_on;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_on    <= 1'b0;
      r_wave  <= 1'b0;
    end else begin
      r_timer <= w_timer;
      r_step  <= w_step;
      r_len   <= w_len;
      r_on    <= w_on;
      r_wave  <= w_wave;
    end
  end

  assign wave_out   = r_wave;
  assign channel_on = r_on;
  assign duty_step  = r_step;

endmodule

// File: tb/tb_square_wave_gen.sv
// Bench for square_wave_gen: directed vector table, multi-cycle corner
// sequences, then random stimulus against an arithmetic reference model.
module tb_square_wave_gen;

  localparam int LM = 64;

  logic        clock;
  logic        reset;
  logic        freq_tick;
  logic        length_tick;
  logic [10:0] frequency;
  logic [1:0]  duty;
  logic        trigger;
  logic        length_enable;
  logic        length_load;
  logic [5:0]  length_data;
  logic        sweep_ok;
  logic        wave_out;
  logic        channel_on;
  logic [2:0]  duty_step;

  square_wave_gen #(.LENGTH_MAX(LM)) dut (
    .clock        (clock),
    .reset        (reset),
    .freq_tick    (freq_tick),
    .length_tick  (length_tick),
    .frequency    (frequency),
    .duty         (duty),
    .trigger      (trigger),
    .length_enable(length_enable),
    .length_load  (length_load),
    .length_data  (length_data),
    .sweep_ok     (sweep_ok),
    .wave_out     (wave_out),
    .channel_on   (channel_on),
    .duty_step    (duty_step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, plain integers
  int m_timer, m_step, m_len, m_on, m_wave;
  logic [7:0] pat [4];

  typedef struct {
    logic trig;
    logic ftick;
    int   exp_step;
    int   exp_wave;
    int   exp_on;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_update();
    int reload;
    int load_val;
    int old_on;
    reload   = 2048 - int'(frequency);
    load_val = LM - int'(length_data);
    old_on   = m_on;
    if (trigger) begin
      m_timer = reload;
      m_step  = 0;
      m_on    = 1;
      if (length_load) m_len = (load_val == 0) ? LM : load_val;
      else if (m_len == 0) m_len = LM;
    end else begin
      if (old_on == 1 && freq_tick) begin
        if (m_timer == 1) begin
          m_timer = reload;
          m_step  = (m_step + 1) % 8;
        end else begin
          m_timer = m_timer - 1;
        end
      end
      if (length_load) m_len = load_val;
      else if (length_tick && length_enable && m_len > 0) begin
        m_len = m_len - 1;
        if (m_len == 0) m_on = 0;
      end
    end
    if (!sweep_ok) m_on = 0;
    m_wave = (m_on == 1) ? int'(pat[duty][m_step]) : 0;
  endtask

  task automatic cycle();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    trigger = 0; freq_tick = 0; length_tick = 0; length_load = 0;
  endtask

  initial begin
    pat[0] = 8'b0000_0001;
    pat[1] = 8'b1000_0001;
    pat[2] = 8'b1000_0111;
    pat[3] = 8'b0111_1110;
    m_timer = 0; m_step = 0; m_len = 0; m_on = 0; m_wave = 0;

    // Duty 10 sequence at frequency 2047: one step per tick
    vecs[0] = '{1'b1, 1'b0, 0, 1, 1};
    vecs[1] = '{1'b0, 1'b1, 1, 1, 1};
    vecs[2] = '{1'b0, 1'b1, 2, 1, 1};
    vecs[3] = '{1'b0, 1'b1, 3, 0, 1};
    vecs[4] = '{1'b0, 1'b1, 4, 0, 1};
    vecs[5] = '{1'b0, 1'b1, 5, 0, 1};
    vecs[6] = '{1'b0, 1'b1, 6, 0, 1};
    vecs[7] = '{1'b0, 1'b1, 7, 1, 1};
    vecs[8] = '{1'b0, 1'b1, 0, 1, 1};

    reset = 0; sweep_ok = 1; frequency = 0; duty = 0; length_enable = 0;
    length_data = 0;
    clear_strobes();
    #12;
    chk("reset_step", int'(duty_step), 0);
    chk("reset_on", int'(channel_on), 0);
    chk("reset_wave", int'(wave_out), 0);
    @(negedge clock);
    reset = 1;
    freq_tick = 1;
    cycle();
    chk("idle_tick_step", int'(duty_step), 0);
    chk("idle_tick_on", int'(channel_on), 0);

    // Basic duty sequence from the vector table
    frequency = 11'd2047; duty = 2'd2;
    for (int i = 0; i < 9; i++) begin
      trigger = vecs[i].trig; freq_tick = vecs[i].ftick;
      cycle();
      chk($sformatf("vec%0d_step", i), int'(duty_step), vecs[i].exp_step);
      chk($sformatf("vec%0d_wave", i), int'(wave_out), vecs[i].exp_wave);
      chk($sformatf("vec%0d_on", i), int'(channel_on), vecs[i].exp_on);
    end
    clear_strobes();

    // Frequency change mid-period only affects the next reload
    begin
      int exp_steps [8];
      exp_steps = '{0, 0, 0, 1, 1, 2, 2, 3};
      frequency = 11'd2044; trigger = 1;
      cycle();
      trigger = 0; freq_tick = 1;
      for (int i = 0; i < 8; i++) begin
        if (i == 2) frequency = 11'd2046;
        cycle();
        chk($sformatf("fchg_tick%0d", i + 1), int'(duty_step), exp_steps[i]);
      end
      freq_tick = 0;
    end

    // Length expiry after two ticks with length_data=62
    duty = 2'd0;
    length_load = 1; length_data = 6'd62;
    cycle();
    length_load = 0; length_enable = 1; trigger = 1;
    cycle();
    trigger = 0; length_tick = 1;
    cycle();
    chk("len_tick1_on", int'(channel_on), 1);
    chk("len_tick1_wave", int'(wave_out), 1);
    cycle();
    chk("len_tick2_on", int'(channel_on), 0);
    chk("len_tick2_wave", int'(wave_out), 0);
    length_tick = 0;

    // Trigger with empty counter reloads LENGTH_MAX
    trigger = 1;
    cycle();
    trigger = 0;
    chk("len_reload_val", int'(dut.r_len), LM);
    length_tick = 1;
    for (int i = 0; i < LM - 1; i++) cycle();
    chk("len_tick63_on", int'(channel_on), 1);
    cycle();
    chk("len_tick64_on", int'(channel_on), 0);
    length_tick = 0; length_enable = 0;

    // Sweep overflow while running and together with a trigger
    duty = 2'd1; trigger = 1;
    cycle();
    trigger = 0;
    chk("sweep_pre_on", int'(channel_on), 1);
    sweep_ok = 0;
    cycle();
    chk("sweep_run_on", int'(channel_on), 0);
    chk("sweep_run_wave", int'(wave_out), 0);
    sweep_ok = 1; trigger = 1;
    cycle();
    chk("sweep_retrig_on", int'(channel_on), 1);
    sweep_ok = 0;
    cycle();
    chk("sweep_trig_on", int'(channel_on), 0);
    chk("sweep_trig_wave", int'(wave_out), 0);
    sweep_ok = 1; trigger = 0;

    // Reset mid-period at duty_step 5
    frequency = 11'd2047; duty = 2'd3; trigger = 1;
    cycle();
    trigger = 0; freq_tick = 1;
    for (int i = 0; i < 5; i++) cycle();
    freq_tick = 0;
    chk("rst_pre_step", int'(duty_step), 5);
    chk("rst_pre_wave", int'(wave_out), 1);
    #2;
    reset = 0;
    #1;
    chk("rst_async_step", int'(duty_step), 0);
    chk("rst_async_on", int'(channel_on), 0);
    chk("rst_async_wave", int'(wave_out), 0);
    @(negedge clock);
    reset = 1;
    freq_tick = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_post_step", int'(duty_step), 0);
    chk("rst_post_on", int'(channel_on), 0);
    freq_tick = 0; trigger = 1;
    cycle();
    trigger = 0;
    chk("rst_retrig_on", int'(channel_on), 1);

    // Random stimulus against the reference model, starting from reset
    clear_strobes();
    reset = 0;
    #1;
    m_timer = 0; m_step = 0; m_len = 0; m_on = 0; m_wave = 0;
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 3000; i++) begin
      trigger     = ($urandom_range(0, 31) == 0);
      freq_tick   = 1'($urandom_range(0, 1));
      length_tick = ($urandom_range(0, 7) == 0);
      length_load = ($urandom_range(0, 31) == 0);
      length_data = 6'($urandom_range(40, 63));
      frequency   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(2040, 2047));
      duty        = 2'($urandom);
      sweep_ok    = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) length_enable = ~length_enable;
      cycle();
      chk($sformatf("rnd%0d_step", i), int'(duty_step), m_step);
      chk($sformatf("rnd%0d_on", i), int'(channel_on), m_on);
      chk($sformatf("rnd%0d_wave", i), int'(wave_out), m_wave);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/square_wave_gen.md
SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

Interface
REQ-001 Parameter: LENGTH_MAX, default 64; length-counter reload value on a trigger while the counter is 0. The counter is 7 bits wide.
REQ-002 Port: clock, input, 1, single system clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous, active-low reset.
REQ-004 Port: freq_tick, input, 1, one-cycle strobe that advances the period timer.
REQ-005 Port: length_tick, input, 1, one-cycle 256 Hz strobe that advances the length counter.
REQ-006 Port: frequency, input, 11, current NR14[2:0]/NR13 value, including sweep write-backs.
REQ-007 Port: duty, input, 2, NR11[7:6] duty select.
REQ-008 Port: trigger, input, 1, one-cycle strobe for an NR14[7] write.
REQ-009 Port: length_enable, input, 1, NR14[6].
REQ-010 Port: length_load, input, 1, one-cycle strobe for an NR11[5:0] write.
REQ-011 Port: length_data, input, 6, NR11[5:0].
REQ-012 Port: sweep_ok, input, 1, sweep no-overflow flag; 0 means overflow.
REQ-013 Port: wave_out, output, 1, square-wave sample.
REQ-014 Port: channel_on, output, 1, channel active flag.
REQ-015 Port: duty_step, output, 3, current position within the 8-step waveform.

Function
REQ-016 The period timer is 12 bits; on a trigger it loads 2048 - frequency (frequency 0 gives 2048, frequency 2047 gives 1).
REQ-017 When channel_on=1 and freq_tick=1:
- If timer==1: reload 2048 - frequency and set duty_step to (duty_step + 1) mod 8, wrapping 7 to 0.
- Otherwise: decrement the timer.
REQ-018 A frequency change mid-period does not alter the running count; the new value takes effect at the next reload.
REQ-019 When channel_on=0, the timer and duty_step hold their values.
REQ-020 The duty waveform is indexed by duty_step, where bit 0 is step 0:
- duty 00: 00000001
- duty 01: 10000001
- duty 10: 10000111
- duty 11: 01111110
REQ-021 wave_out is registered: on each edge it takes pattern[duty][next duty_step] AND next channel_on. It is therefore never 1 while channel_on=0.
REQ-022 A trigger has the following effect on the next edge:
- timer is reloaded (REQ-016);
- duty_step is set to 0;
- channel_on is set to 1;
- if the length counter is 0, it is loaded with LENGTH_MAX.
REQ-023 On a length_load, the length counter is set to LENGTH_MAX - length_data.
REQ-024 When length_tick=1, length_enable=1 and the counter is nonzero, the counter decrements. On the transition to 0, channel_on clears on that same edge.
REQ-025 When sweep_ok=0 at an edge, channel_on clears on that edge and wave_out becomes 0. This overrides a simultaneous trigger.
REQ-026 Simultaneous events are resolved as follows:
- trigger with freq_tick: the trigger wins and the timer is not decremented;
- trigger with length_tick: the trigger reload happens first and no decrement occurs that cycle;
- trigger with length_load: the length_load value is used, and it is replaced by LENGTH_MAX only if that value is 0.
REQ-027 While the counter is 0 or length_enable=0, length_tick has no effect.

Reset
REQ-028 While reset=0, the following are all forced to 0 asynchronously: timer, duty_step, length counter, channel_on and wave_out.
REQ-029 Reset asserted mid-period aborts all activity; after release, no output changes until a trigger occurs.

Verification
REQ-030 Basic duty sequence:
- Stimulus: frequency=2047, duty=10, trigger, then freq_tick every cycle.
- Response: duty_step steps 0,1,...,7,0 one per tick; wave_out follows 1,1,1,0,0,0,0,1.
REQ-031 Frequency change mid-period:
- Stimulus: frequency=2044 (period 4), trigger, two ticks, then frequency changed to 2046.
- Response: the first step occurs after tick 4; the following steps occur every 2 ticks.
REQ-032 Length expiry:
- Stimulus: length_data=62 loaded, length_enable=1, trigger, then two length_ticks.
- Response: channel_on=0 and wave_out=0 after the second tick.
REQ-033 Length reload on trigger:
- Stimulus: trigger with the length counter at 0 and length_enable=1.
- Response: the counter equals 64; channel_on drops after the 64th length_tick.
REQ-034 Sweep overflow override:
- Stimulus: sweep_ok=0 while running; separately, trigger and sweep_ok=0 in the same cycle.
- Response: channel_on=0 on the next edge in both cases.
REQ-035 Reset mid-period:
- Stimulus: reset pulsed low mid-period with duty_step=5.
- Response: all outputs are 0 immediately; freq_ticks have no effect until the next trigger.
